// File: rtl/boreal_channel_serializer.sv
// Serializes a parallel per-channel frame into a channel-multiplexed sample stream.
// One-frame holding buffer in front of the emitter; frames arriving while it is full are dropped and counted.
module boreal_channel_serializer #(
  parameter int CHANNELS   = 8,
  parameter int SAMPLE_W   = 16,
  parameter int CH_W       = 3,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic signed [SAMPLE_W-1:0]   filtered_sample,
  output logic [CH_W-1:0]              channel_sel,
  output logic                         sample_valid,
  output logic                         frame_done,
  output logic                         busy,
  output logic [7:0]                   overrun_count
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [3:0]      GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t                            state_q, state_d;
  logic [CHANNELS-1:0][SAMPLE_W-1:0] pend_q, pend_d, act_q, act_d;
  logic                              pend_full_q, pend_full_d;
  logic [CH_W-1:0]                   ch_q, ch_d;
  logic [3:0]                        gap_q, gap_d;
  logic [SAMPLE_W-1:0]               sample_q, sample_d;
  logic                              vld_q, vld_d;
  logic                              done_q, done_d;
  logic [7:0]                        ovr_q, ovr_d;
  logic                              load;
  logic                              do_emit;
  logic [CH_W-1:0]                   emit_ch;

  // ch_q is the last emitted channel; in S_EMIT every edge is an output slot.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    ch_d     = ch_q;
    gap_d    = gap_q;
    sample_d = sample_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    do_emit  = 1'b0;
    emit_ch  = ch_q;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          load    = 1'b1;
          do_emit = 1'b1;
          emit_ch = '0;
        end
      end
      S_EMIT: begin
        if (ch_q == LAST_CH) begin
          if (pend_full_q) begin
            load    = 1'b1;
            do_emit = 1'b1;
            emit_ch = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          do_emit = 1'b1;
          emit_ch = ch_q + CH_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_EMIT;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      act_d = pend_q;
    end

    if (do_emit) begin
      sample_d = act_d[emit_ch];
      ch_d     = emit_ch;
      vld_d    = 1'b1;
      done_d   = (emit_ch == LAST_CH);
      state_d  = (GAP_CYCLES > 0) ? S_GAP : S_EMIT;
      gap_d    = GAP_INIT;
    end
  end

  // A strobe on a load edge refills the buffer being vacated, so it is never an overrun.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ovr_d       = ovr_q;

    if (load) begin
      pend_full_d = 1'b0;
    end

    if (frame_valid) begin
      if (!pend_full_q || load) begin
        pend_d      = frame_data;
        pend_full_d = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      act_q       <= '0;
      pend_full_q <= 1'b0;
      ch_q        <= '0;
      gap_q       <= 4'd0;
      sample_q    <= '0;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_full_q <= pend_full_d;
      ch_q        <= ch_d;
      gap_q       <= gap_d;
      sample_q    <= sample_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign frame_ready     = !pend_full_q;
  assign filtered_sample = sample_q;
  assign channel_sel     = ch_q;
  assign sample_valid    = vld_q;
  assign frame_done      = done_q;
  assign busy            = (state_q != S_IDLE);
  assign overrun_count   = ovr_q;

endmodule

// File: tb/tb_boreal_channel_serializer.sv
// Directed bench for boreal_channel_serializer: one instance with no gap, one with a 2-cycle gap,
// expected samples queued at stimulus time and consumed by per-instance output monitors.
module tb_boreal_channel_serializer;

  localparam int CH = 8;
  localparam int W  = 16;

  typedef struct {
    int ch;
    int s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CH*W-1:0] fd0, fd2;
  logic          fv0, fv2;

  logic          rdy0, sv0, done0, busy0;
  logic signed [W-1:0] fs0;
  logic [2:0]    cs0;
  logic [7:0]    ovr0;

  logic          rdy2, sv2, done2, busy2;
  logic signed [W-1:0] fs2;
  logic [2:0]    cs2;
  logic [7:0]    ovr2;

  boreal_channel_serializer #(.CHANNELS(CH), .SAMPLE_W(W), .CH_W(3), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_data(fd0), .frame_valid(fv0), .frame_ready(rdy0),
    .filtered_sample(fs0), .channel_sel(cs0), .sample_valid(sv0), .frame_done(done0),
    .busy(busy0), .overrun_count(ovr0)
  );

  boreal_channel_serializer #(.CHANNELS(CH), .SAMPLE_W(W), .CH_W(3), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_data(fd2), .frame_valid(fv2), .frame_ready(rdy2),
    .filtered_sample(fs2), .channel_sel(cs2), .sample_valid(sv2), .frame_done(done2),
    .busy(busy2), .overrun_count(ovr2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q0[$];
  exp_t q2[$];
  bit   sb_on0 = 1'b1;
  int   vld_cnt0 = 0, run0 = 0, max_run0 = 0, first0 = -1, last0 = 0;
  int   first2 = -1, last2 = 0, ch7_2 = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ok(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed timeout expected completion", tag);
    end
  endtask

  function automatic logic [CH*W-1:0] mk(input int base, input int step);
    logic [CH*W-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r[k*W +: W] = 16'(base + step * k);
    return r;
  endfunction

  task automatic exp0(input int base, input int step);
    for (int k = 0; k < CH; k++) q0.push_back('{k, base + step * k});
  endtask

  task automatic exp2(input int base, input int step);
    for (int k = 0; k < CH; k++) q2.push_back('{k, base + step * k});
  endtask

  // Called at a negedge; the strobe is sampled at the next posedge and the task returns one negedge later.
  task automatic strobe0(input logic [CH*W-1:0] d);
    fd0 = d;
    fv0 = 1'b1;
    @(negedge clk);
    fv0 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag, output int idle_cyc);
    bit ok;
    ok = 1'b0;
    idle_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && !busy0 && !sv0) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    chk_ok(tag, ok);
  endtask

  // Monitor for the no-gap instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sv0) begin
        vld_cnt0++;
        run0++;
        if (run0 > max_run0) max_run0 = run0;
        if (first0 < 0) first0 = cyc;
        last0 = cyc;
        if (sb_on0) begin
          if (q0.size() == 0) begin
            chk("unexpected_valid0", sv0, 1'b0);
          end else begin
            e = q0.pop_front();
            chk("chan0", cs0, e.ch);
            chk("sample0", fs0, e.s);
            chk("done0", done0, (e.ch == CH - 1));
          end
        end
      end else begin
        run0 = 0;
        chk("done_idle0", done0, 1'b0);
      end
    end
  end

  // Monitor for the gap instance; also checks slot spacing within a frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sv2) begin
      if (q2.size() == 0) begin
        chk("unexpected_valid2", sv2, 1'b0);
      end else begin
        e = q2.pop_front();
        chk("chan2", cs2, e.ch);
        chk("sample2", fs2, e.s);
        chk("done2", done2, (e.ch == CH - 1));
        if (e.ch == 0) first2 = cyc;
        else chk("spacing2", cyc - last2, 3);
        if (e.ch == CH - 1) ch7_2 = cyc;
        last2 = cyc;
      end
    end
  end

  initial begin
    int sc;
    int idle_c;
    int vc;
    bit ok;

    rst_n = 1'b0;
    fv0 = 1'b0;
    fv2 = 1'b0;
    fd0 = '0;
    fd2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sample", fs0, 0);
    chk("rst_chsel", cs0, 0);
    chk("rst_valid", sv0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_ready2", rdy2, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, no gap
    exp0(-300, 100);
    first0 = -1;
    max_run0 = 0;
    strobe0(mk(-300, 100));
    sc = cyc;
    chk("t1_ready_after_strobe", rdy0, 0);
    wait_idle0("t1_idle", idle_c);
    chk("t1_latency", first0 - sc, 1);
    chk("t1_run", max_run0, 8);
    chk("t1_busy_fall", idle_c - last0, 1);
    chk("t1_ready_end", rdy0, 1);

    // Single frame with 2-cycle gap
    exp2(1000, -7);
    fd2 = mk(1000, -7);
    fv2 = 1'b1;
    @(negedge clk);
    fv2 = 1'b0;
    sc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q2.size() == 0 && !busy2 && !sv2) begin
        ok = 1'b1;
        break;
      end
    end
    chk_ok("t4_idle", ok);
    chk("t4_latency", first2 - sc, 1);
    chk("t4_window", ch7_2 - first2 + 1, 22);
    chk("t4_ovr", ovr2, 0);

    // Two strobes 8 cycles apart: continuous stream
    exp0(10, 1);
    exp0(-20, -3);
    first0 = -1;
    max_run0 = 0;
    strobe0(mk(10, 1));
    repeat (7) @(negedge clk);
    strobe0(mk(-20, -3));
    wait_idle0("t2_idle", idle_c);
    chk("t2_run", max_run0, 16);
    chk("t2_ovr", ovr0, 0);

    // Second strobe lands on the load edge
    exp0(500, 11);
    exp0(-500, 13);
    max_run0 = 0;
    strobe0(mk(500, 11));
    strobe0(mk(-500, 13));
    wait_idle0("t5_idle", idle_c);
    chk("t5_run", max_run0, 16);
    chk("t5_ovr", ovr0, 0);

    // Three back-to-back strobes: third dropped
    exp0(7, 2);
    exp0(-7, -2);
    max_run0 = 0;
    fd0 = mk(7, 2);
    fv0 = 1'b1;
    @(negedge clk);
    fd0 = mk(-7, -2);
    @(negedge clk);
    fd0 = mk(9999, 1);
    @(negedge clk);
    fv0 = 1'b0;
    wait_idle0("t3_idle", idle_c);
    chk("t3_ovr", ovr0, 1);
    chk("t3_run", max_run0, 16);

    // Hundreds of drop events: counter saturates
    sb_on0 = 1'b0;
    fd0 = mk(1, 1);
    fv0 = 1'b1;
    repeat (400) @(negedge clk);
    fv0 = 1'b0;
    wait_idle0("t3_sat_idle", idle_c);
    sb_on0 = 1'b1;
    chk("t3_ovr_sat", ovr0, 255);

    // Reset during ch3 with a frame held
    exp0(40, 5);
    strobe0(mk(40, 5));
    @(negedge clk);
    strobe0(mk(-40, -5));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sv0 && cs0 == 3'd3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_ok("t6_reach_ch3", ok);
    chk("t6_held", rdy0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    chk("t6_sample", fs0, 0);
    chk("t6_chsel", cs0, 0);
    chk("t6_valid", sv0, 0);
    chk("t6_done", done0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_ovr", ovr0, 0);
    chk("t6_ready", rdy0, 1);
    rst_n = 1'b1;
    vc = vld_cnt0;
    repeat (30) @(negedge clk);
    chk("t6_no_valid", vld_cnt0 - vc, 0);

    exp0(123, -45);
    first0 = -1;
    max_run0 = 0;
    strobe0(mk(123, -45));
    sc = cyc;
    wait_idle0("t6_restart_idle", idle_c);
    chk("t6_restart_latency", first0 - sc, 1);
    chk("t6_restart_run", max_run0, 8);
    chk("t6_restart_ovr", ovr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boreal_channel_serializer.md
Name: boreal_channel_serializer

Overview:
Turns one parallel frame of per-channel filtered samples into the channel-multiplexed stream (filtered_sample, channel_sel, sample_valid) used by the cursor feature extraction stage. It sits between the filter bank, which delivers all channels at once on a single-cycle strobe, and the feature extractor, which consumes one channel per valid cycle in order 0..CHANNELS-1. It provides a one-frame holding buffer, optional spacing between samples, and overrun accounting, because the filter bank cannot be stalled.

Parameters:
CHANNELS, 8, number of channels per frame; channel_sel counts 0..CHANNELS-1.
SAMPLE_W, 16, signed sample width.
CH_W, 3, channel_sel width; must satisfy 2^CH_W >= CHANNELS.
GAP_CYCLES, 0, idle cycles inserted after every emitted sample; range 0..15.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
frame_data  in  CHANNELS*SAMPLE_W  packed frame; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
frame_valid  in  1  single-cycle strobe meaning frame_data is valid; no backpressure.
frame_ready  out  1  combinational: high when the holding buffer is empty.
filtered_sample  out  SAMPLE_W  signed sample for the current channel (registered).
channel_sel  out  CH_W  channel index of filtered_sample (registered).
sample_valid  out  1  one-cycle qualifier per emitted sample (registered).
frame_done  out  1  pulses with the sample_valid of channel CHANNELS-1.
busy  out  1  high while a frame is being emitted (state != IDLE).
overrun_count  out  8  dropped-frame counter; saturates at 255.

Behaviour:
- Reset: filtered_sample=0, channel_sel=0, sample_valid=0, frame_done=0, busy=0, overrun_count=0, holding buffer empty (frame_ready=1), state IDLE.
- Reset mid-frame discards both the active and the held frame. No further sample_valid is produced until a new frame_valid arrives.
- Storage: holding register (pend, pend_full) and active register (act).
- Accept: frame_valid=1 with pend_full=0 writes pend and sets pend_full at that edge.
- Drop: frame_valid=1 with pend_full=1 discards frame_data, keeps pend unchanged, and increments overrun_count (saturating).
- Load: a load copies pend to act and clears pend_full at the same edge.
- Simultaneous load and strobe at one edge: the new frame is accepted. pend takes the new data, pend_full stays 1, and no overrun is counted.
- States:
  - IDLE: sample_valid=0. If pend_full, then at the next edge: load, emit ch0, go to EMIT (or GAP if GAP_CYCLES>0).
  - EMIT: one output slot per edge. Register filtered_sample=act[ch], channel_sel=ch, sample_valid=1.
  - GAP: holds sample_valid=0 for GAP_CYCLES edges, using a 4-bit counter, then returns to the slot sequence.
- Frame end: after the slot for ch=CHANNELS-1, the next slot edge does one of two things.
  - pend_full: load and emit ch0 of the new frame. With GAP_CYCLES=0, sample_valid stays continuously high across frames.
  - Otherwise: go to IDLE with sample_valid=0.
- Latency: a strobe sampled at edge N with the buffer idle gives ch0 valid after edge N+1. Channel k appears after edge N+1+k*(GAP_CYCLES+1).
- frame_done=1 exactly in the cycle where channel_sel=CHANNELS-1 and sample_valid=1; otherwise 0.
- filtered_sample and channel_sel hold their last values while sample_valid=0.
- Channel order is strictly ascending. Channels are never skipped or repeated within a frame.
- Throughput at GAP_CYCLES=0: one frame per CHANNELS cycles. Strobes spaced at least CHANNELS cycles apart never overrun. Two strobes within a single emission window overrun once the buffer is already full.

Test Plan:
1. GAP_CYCLES=0, one strobe with ch k = 100*k-300 -> 8 consecutive sample_valid cycles starting one cycle after the strobe edge. Values -300,-200,...,400 on channel_sel 0..7. frame_done only with ch7; busy falls after it.
2. Two strobes 8 cycles apart (frames A, B) -> 16 continuous sample_valid cycles, B ch0 immediately after A ch7, overrun_count=0.
3. Three strobes on consecutive cycles -> frames 1 and 2 emitted in order, third dropped, overrun_count=1. Repeat 300 drop events -> overrun_count=255.
4. GAP_CYCLES=2, one frame -> sample_valid every 3rd cycle, channel_sel 0..7, total window 22 cycles from first to last valid.
5. Strobe a second frame on the exact edge that loads pend into act -> accepted with no overrun; emitted after the first frame.
6. Assert rst_n=0 for one cycle during ch3 of a frame with a second frame held -> all outputs 0 and frame_ready=1 next cycle, no further sample_valid. A new strobe then restarts cleanly at ch0.
